// File: rtl/display_pkg.sv
// Shared types and constants for the result display: FSM encoding, segment
// patterns (active-low {g,f,e,d,c,b,a}) and double-dabble step count.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int RESULT_W = 13;
  localparam int BCD_W    = 16;
  localparam int DD_STEPS = 13;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern; blank forces all
// segments off. Non-decimal codes also render blank.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/result_display.sv
// 13-bit ALU result -> 4-digit multiplexed 7-segment display via a sequential
// double-dabble converter. Define SIGNED_DISPLAY_EN for two's-complement display.
module result_display
  import display_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [RESULT_W-1:0] result,
  output logic [6:0]          seg,
  output logic [3:0]          an,
  output logic                dp,
  output logic                busy
);

  state_t               state;
  logic [RESULT_W-1:0]  cap;
  logic [RESULT_W-1:0]  sh;
  logic [BCD_W-1:0]     bcd;
  logic [BCD_W-1:0]     digits;
  logic [3:0]           cnt;
  logic [REFRESH_BITS-1:0] ctr;
  logic [1:0]           sel;
  logic [3:0]           cur_digit;
  logic [3:0]           blank;
  logic [6:0]           dec_seg;
  logic [6:0]           seg_nxt;
`ifdef SIGNED_DISPLAY_EN
  logic                 neg_conv;
  logic                 neg_disp;
`endif

  // One double-dabble step: bias every nibble >= 5 by 3, then shift in the next bit.
  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] b,
                                               input logic in_bit);
    logic [BCD_W-1:0] a;
    a = b;
    for (int i = 0; i < 4; i++) begin
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return {a[BCD_W-2:0], in_bit};
  endfunction

`ifdef SIGNED_DISPLAY_EN
  function automatic logic [RESULT_W-1:0] magnitude(input logic [RESULT_W-1:0] v);
    logic signed [RESULT_W:0] s;
    s = {v[RESULT_W-1], v};
    if (s < 0) s = -s;
    return s[RESULT_W-1:0];
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cap    <= '0;
      sh     <= '0;
      bcd    <= '0;
      cnt    <= '0;
      digits <= '0;
      busy   <= 1'b0;
`ifdef SIGNED_DISPLAY_EN
      neg_conv <= 1'b0;
      neg_disp <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (result != cap) begin
            cap   <= result;
`ifdef SIGNED_DISPLAY_EN
            sh       <= magnitude(result);
            neg_conv <= result[RESULT_W-1];
`else
            sh    <= result;
`endif
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          bcd <= dd_step(bcd, sh[RESULT_W-1]);
          sh  <= {sh[RESULT_W-2:0], 1'b0};
          cnt <= cnt + 4'd1;
          if (cnt == 4'(DD_STEPS - 1)) state <= DONE;
        end
        DONE: begin
          digits <= bcd;
`ifdef SIGNED_DISPLAY_EN
          neg_disp <= neg_conv;
`endif
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sel       = ctr[REFRESH_BITS-1 -: 2];
  assign cur_digit = digits[{sel, 2'b00} +: 4];

  // A position is blank when it and every position to its left are zero.
  always_comb begin
    blank    = 4'b0000;
    blank[1] = (digits[15:4]  == '0);
    blank[2] = (digits[15:8]  == '0);
    blank[3] = (digits[15:12] == '0);
  end

  seg7_decoder u_dec (
    .digit (cur_digit),
    .blank (blank[sel]),
    .seg   (dec_seg)
  );

  always_comb begin
    seg_nxt = dec_seg;
`ifdef SIGNED_DISPLAY_EN
    // Negative magnitudes above 999 do not fit beside the sign: show "----".
    if (neg_disp && ((sel == 2'd3) || (digits[15:12] != '0))) seg_nxt = SEG_MINUS;
`endif
  end

  // Display output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      ctr <= '0;
      an  <= 4'hF;
      seg <= SEG_BLANK;
    end else begin
      ctr <= ctr + 1'b1;
      an  <= ~(4'b0001 << sel);
      seg <= seg_nxt;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display with a short refresh counter; expected
// segment patterns are hand-computed in the vector table.
module tb_result_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] result;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [12:0]     res;
    logic [3:0][6:0] us;
    logic [3:0][6:0] sg;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  result_display #(.REFRESH_BITS(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .result (result),
    .seg    (seg),
    .an     (an),
    .dp     (dp),
    .busy   (busy)
  );

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic read_frame(output logic [3:0][6:0] got, output int oh_err,
                            output int busy_hi);
    got     = {4{7'h55}};
    oh_err  = 0;
    busy_hi = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (busy) busy_hi++;
      case (an)
        4'b1110: got[0] = seg;
        4'b1101: got[1] = seg;
        4'b1011: got[2] = seg;
        4'b0111: got[3] = seg;
        default: oh_err++;
      endcase
    end
  endtask

  task automatic check_frame(input string name, input logic [3:0][6:0] exp);
    logic [3:0][6:0] got;
    int oh, bh;
    read_frame(got, oh, bh);
    check({name, "_an_onehot"}, oh, 0);
    for (int p = 0; p < 4; p++)
      check($sformatf("%s_seg%0d", name, p), got[p], exp[p]);
  endtask

  task automatic wait_rise(input string name);
    for (int k = 0; k < 40 && !busy; k++) @(negedge clk);
    check({name, "_busy_rise"}, busy, 1);
  endtask

  task automatic count_busy(input string name, output int n);
    n = 0;
    for (int k = 0; k < 60 && busy; k++) begin
      n++;
      @(negedge clk);
    end
    check({name, "_busy_fall"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi, lows, falls, oh, bh;
    logic prev;
    logic [3:0][6:0] got;

    vecs[0] = '{13'd3969, {7'h30,7'h10,7'h02,7'h10}, {7'h30,7'h10,7'h02,7'h10}};
    vecs[1] = '{13'd8191, {7'h00,7'h79,7'h10,7'h79}, {7'h3F,7'h7F,7'h7F,7'h79}};
    vecs[2] = '{13'd7,    {7'h7F,7'h7F,7'h7F,7'h78}, {7'h7F,7'h7F,7'h7F,7'h78}};
    vecs[3] = '{13'd1000, {7'h79,7'h40,7'h40,7'h40}, {7'h79,7'h40,7'h40,7'h40}};
    vecs[4] = '{13'd305,  {7'h7F,7'h30,7'h40,7'h12}, {7'h7F,7'h30,7'h40,7'h12}};
    vecs[5] = '{13'd50,   {7'h7F,7'h7F,7'h12,7'h40}, {7'h7F,7'h7F,7'h12,7'h40}};
    vecs[6] = '{13'd0,    {7'h7F,7'h7F,7'h7F,7'h40}, {7'h7F,7'h7F,7'h7F,7'h40}};
    vecs[7] = '{13'h1FFB, {7'h00,7'h79,7'h00,7'h78}, {7'h3F,7'h7F,7'h7F,7'h12}};
    vecs[8] = '{13'h1C00, {7'h78,7'h79,7'h02,7'h00}, {7'h3F,7'h3F,7'h3F,7'h3F}};
    vecs[9] = '{13'd4095, {7'h19,7'h40,7'h10,7'h12}, {7'h19,7'h40,7'h10,7'h12}};

    // Reset state and idle display of zero
    reset  = 1'b1;
    result = 13'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1);
    reset = 1'b0;
    read_frame(got, oh, bh);
    check("zero_no_conv", bh, 0);
    check("zero_onehot", oh, 0);
    check("zero_seg0", got[0], 7'h40);
    check("zero_seg3", got[3], 7'h7F);

    // Table-driven conversions
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      result = vecs[i].res;
      wait_rise($sformatf("v%0d", i));
      count_busy($sformatf("v%0d", i), n);
      check($sformatf("v%0d_busy_len", i), n, 14);
`ifdef SIGNED_DISPLAY_EN
      check_frame($sformatf("v%0d", i), vecs[i].sg);
`else
      check_frame($sformatf("v%0d", i), vecs[i].us);
`endif
    end

    // Input change during conversion: final value wins, busy drops once
    @(negedge clk);
    result = 13'd42;
    wait_rise("chg");
    hi = 0; lows = 0; falls = 0; prev = 1'b1;
    for (int k = 0; k < 80 && falls < 2; k++) begin
      if (busy) hi++;
      else if (falls == 1) lows++;
      if (prev && !busy) falls++;
      if (busy && hi == 5) result = 13'd100;
      prev = busy;
      @(negedge clk);
    end
    check("chg_falls", falls, 2);
    check("chg_busy_total", hi, 28);
    check("chg_gap", lows, 1);
    check_frame("chg100", {7'h7F, 7'h79, 7'h40, 7'h40});

    // Reset in the middle of a conversion
    @(negedge clk);
    result = 13'd500;
    wait_rise("rmid");
    repeat (3) @(negedge clk);
    check("rmid_busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rmid_busy", busy, 0);
    check("rmid_an", an, 4'hF);
    check("rmid_seg", seg, 7'h7F);
    reset = 1'b0;
    @(negedge clk);
    check("rmid_restart", busy, 1);
    check("rmid_an0", an, 4'b1110);
    check("rmid_digit0_cleared", seg, 7'h40);
    count_busy("rmid", n);
    check("rmid_busy_len", n, 14);
    check_frame("rmid500", {7'h7F, 7'h12, 7'h40, 7'h40});

    // Stable input must not retrigger
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) hi++;
    end
    check("stable_no_restart", hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
